// File: rtl/agu_scheduler.sv
// Round-robin scheduler sharing one address generation unit between NUM_REQ clients.
// Latches and validates a descriptor, runs the AGU start/done handshake and tags the address stream.
package accel_pkg;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    SEQUENTIAL = 2'd0,
    STRIDED    = 2'd1,
    SLIDING_2D = 2'd2,
    GATHER     = 2'd3
  } access_pattern_e;
endpackage

module agu_scheduler
  import accel_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  access_pattern_e [NUM_REQ-1:0]        req_pattern,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_base,
  input  logic [NUM_REQ-1:0][15:0]             req_length,
  input  logic [NUM_REQ-1:0][7:0]              req_stride,
  input  logic [NUM_REQ-1:0][7:0]              req_width,
  input  logic [NUM_REQ-1:0][7:0]              req_height,
  input  logic [NUM_REQ-1:0][7:0]              req_ksize,
  output logic                                 agu_start,
  output access_pattern_e                      agu_pattern,
  output logic [ADDR_WIDTH-1:0]                agu_base_addr,
  output logic [15:0]                          agu_length,
  output logic [7:0]                           agu_stride,
  output logic [7:0]                           agu_width,
  output logic [7:0]                           agu_height,
  output logic [7:0]                           agu_kernel_size,
  input  logic                                 agu_done,
  input  logic [ADDR_WIDTH-1:0]                agu_addr,
  input  logic                                 agu_addr_valid,
  output logic                                 agu_addr_ready,
  output logic [ADDR_WIDTH-1:0]                m_addr,
  output logic                                 m_addr_valid,
  input  logic                                 m_addr_ready,
  output logic [ID_W-1:0]                      m_addr_id,
  output logic                                 cmp_valid,
  output logic [ID_W-1:0]                      cmp_id,
  output logic                                 cmp_err,
  output logic                                 busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  function automatic logic desc_invalid(input access_pattern_e pat, input logic [15:0] len,
                                        input logic [7:0] stride, input logic [7:0] width,
                                        input logic [7:0] height, input logic [7:0] ksize);
    logic bad;
    bad = (len == 16'd0);
    if (pat == SLIDING_2D) begin
      bad = bad | (stride == 8'd0) | (ksize == 8'd0) | (ksize > width) | (ksize > height);
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       cur_id_q, cur_id_d;
  logic                  err_q, err_d;
  access_pattern_e       pattern_q, pattern_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           length_q, length_d;
  logic [7:0]            stride_q, stride_d, width_q, width_d;
  logic [7:0]            height_q, height_d, ksize_q, ksize_d;
  logic                  agu_start_q, agu_start_d;
  logic                  cmp_valid_q, cmp_valid_d;
  logic [ID_W-1:0]       cmp_id_q, cmp_id_d;
  logic                  cmp_err_q, cmp_err_d;
  logic                  busy_q, busy_d;

  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_idx;
  int                    cand;
  logic                  in_run;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!gnt_found && req_valid[ID_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end else begin
        gnt_found = gnt_found;
      end
    end
  end

  // Next-state, descriptor capture and registered output computation.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_id_d = cur_id_q;
    err_d    = err_q;
    pattern_d = pattern_q;
    base_d   = base_q;
    length_d = length_q;
    stride_d = stride_q;
    width_d  = width_q;
    height_d = height_q;
    ksize_d  = ksize_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          cur_id_d  = gnt_idx;
          rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          pattern_d = req_pattern[gnt_idx];
          base_d    = req_base[gnt_idx];
          length_d  = req_length[gnt_idx];
          stride_d  = req_stride[gnt_idx];
          width_d   = req_width[gnt_idx];
          height_d  = req_height[gnt_idx];
          ksize_d   = req_ksize[gnt_idx];
          err_d     = desc_invalid(req_pattern[gnt_idx], req_length[gnt_idx], req_stride[gnt_idx],
                                   req_width[gnt_idx], req_height[gnt_idx], req_ksize[gnt_idx]);
          state_d   = err_d ? S_RESP : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (agu_done) state_d = S_RELEASE;
        else          state_d = S_RUN;
      end
      S_RELEASE: begin
        if (!agu_done) state_d = S_RESP;
        else           state_d = S_RELEASE;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Control and completion outputs decode the next state so they come straight from flops.
    agu_start_d = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    cmp_valid_d = (state_d == S_RESP);
    cmp_err_d   = (state_d == S_RESP) & err_d;
    cmp_id_d    = (state_d == S_RESP) ? cur_id_d : cmp_id_q;
  end

  // State and descriptor registers; a reset mid-job drops it without a completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      err_q       <= 1'b0;
      pattern_q   <= SEQUENTIAL;
      base_q      <= '0;
      length_q    <= 16'd0;
      stride_q    <= 8'd0;
      width_q     <= 8'd0;
      height_q    <= 8'd0;
      ksize_q     <= 8'd0;
      agu_start_q <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_id_q    <= '0;
      cmp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      err_q       <= err_d;
      pattern_q   <= pattern_d;
      base_q      <= base_d;
      length_q    <= length_d;
      stride_q    <= stride_d;
      width_q     <= width_d;
      height_q    <= height_d;
      ksize_q     <= ksize_d;
      agu_start_q <= agu_start_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_id_q    <= cmp_id_d;
      cmp_err_q   <= cmp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Accept strobe and address-stream pass-through, both gated by state.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
    in_run         = (state_q == S_RUN);
    m_addr         = agu_addr;
    m_addr_valid   = in_run & agu_addr_valid;
    agu_addr_ready = in_run & m_addr_ready;
    m_addr_id      = cur_id_q;
  end

  assign agu_start       = agu_start_q;
  assign agu_pattern     = pattern_q;
  assign agu_base_addr   = base_q;
  assign agu_length      = length_q;
  assign agu_stride      = stride_q;
  assign agu_width       = width_q;
  assign agu_height      = height_q;
  assign agu_kernel_size = ksize_q;
  assign cmp_valid       = cmp_valid_q;
  assign cmp_id          = cmp_id_q;
  assign cmp_err         = cmp_err_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_agu_scheduler.sv
// Scoreboard bench for agu_scheduler with a behavioural sequential AGU.
module tb_agu_scheduler;
  import accel_pkg::*;

  localparam int NR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_n = 1'b0;
  logic [NR-1:0]                 req_valid = '0;
  logic [NR-1:0]                 req_ready;
  access_pattern_e [NR-1:0]      req_pattern;
  logic [NR-1:0][ADDR_WIDTH-1:0] req_base;
  logic [NR-1:0][15:0]           req_length;
  logic [NR-1:0][7:0]            req_stride, req_width, req_height, req_ksize;
  logic                          agu_start;
  access_pattern_e               agu_pattern;
  logic [ADDR_WIDTH-1:0]         agu_base_addr;
  logic [15:0]                   agu_length;
  logic [7:0]                    agu_stride, agu_width, agu_height, agu_kernel_size;
  logic                          agu_done;
  logic [ADDR_WIDTH-1:0]         agu_addr;
  logic                          agu_addr_valid, agu_addr_ready;
  logic [ADDR_WIDTH-1:0]         m_addr;
  logic                          m_addr_valid;
  logic                          m_addr_ready = 1'b1;
  logic [1:0]                    m_addr_id;
  logic                          cmp_valid;
  logic [1:0]                    cmp_id;
  logic                          cmp_err;
  logic                          busy;

  agu_scheduler #(.NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_pattern(req_pattern),
    .req_base(req_base), .req_length(req_length), .req_stride(req_stride),
    .req_width(req_width), .req_height(req_height), .req_ksize(req_ksize),
    .agu_start(agu_start), .agu_pattern(agu_pattern), .agu_base_addr(agu_base_addr),
    .agu_length(agu_length), .agu_stride(agu_stride), .agu_width(agu_width),
    .agu_height(agu_height), .agu_kernel_size(agu_kernel_size), .agu_done(agu_done),
    .agu_addr(agu_addr), .agu_addr_valid(agu_addr_valid), .agu_addr_ready(agu_addr_ready),
    .m_addr(m_addr), .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .m_addr_id(m_addr_id), .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_err(cmp_err),
    .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // AGU model: one idle cycle after the last address, then done held until start falls.
  logic [1:0]  agu_ph;
  logic [31:0] agu_cur;
  logic [15:0] agu_rem;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agu_ph <= 2'd0; agu_cur <= 32'd0; agu_rem <= 16'd0;
    end else begin
      case (agu_ph)
        2'd0: if (agu_start) begin agu_cur <= agu_base_addr; agu_rem <= agu_length; agu_ph <= 2'd1; end
        2'd1: if (agu_addr_valid && agu_addr_ready) begin
                agu_cur <= agu_cur + 32'd1;
                agu_rem <= agu_rem - 16'd1;
                if (agu_rem == 16'd1) agu_ph <= 2'd2;
              end
        2'd2: agu_ph <= 2'd3;
        default: if (!agu_start) agu_ph <= 2'd0;
      endcase
    end
  end
  assign agu_addr       = agu_cur;
  assign agu_addr_valid = (agu_ph == 2'd1);
  assign agu_done       = (agu_ph == 2'd3);

  logic bp_mode = 1'b0;
  always @(posedge clk) m_addr_ready <= bp_mode ? ~m_addr_ready : 1'b1;

  int n_checks = 0, n_errors = 0;
  logic [31:0] exp_addr[$];
  logic [1:0]  exp_addr_id[$];
  logic [1:0]  exp_cmp_id[$];
  logic        exp_cmp_err[$];
  int grant_log[$];
  int comp_count[NR];
  int model_ptr = 0;
  int n_grant = 0, n_cmp = 0, n_addr = 0, n_start = 0, job_addrs = 0;
  int accept_cyc = 0, last_cmp_cyc = 0, done_rise_cyc = 0, start_rise_cyc = 0, busy_fall_cyc = 0;
  int first_addr_cyc = 0, last_addr_cyc = 0;
  logic [31:0] exp_base = 32'd0;
  logic [15:0] exp_len = 16'd0;
  logic prev_done = 1'b0, prev_start = 1'b0, prev_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_invalid(input logic [1:0] g);
    if (req_length[g] == 16'd0) return 1'b1;
    if (req_pattern[g] == SLIDING_2D &&
        (req_stride[g] == 8'd0 || req_ksize[g] == 8'd0 ||
         req_ksize[g] > req_width[g] || req_ksize[g] > req_height[g])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic monitor();
    int eg;
    logic [1:0] c, g;
    bit inv;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0; prev_start = 1'b0; prev_busy = 1'b0;
      end else begin
        if (req_ready != 3'b000) begin
          check_eq("ready_only_idle", 32'(busy), 32'd0);
          eg = -1;
          for (int i = 0; i < NR; i++) begin
            c = 2'((model_ptr + i) % NR);
            if (eg < 0 && req_valid[c]) eg = int'(c);
          end
          if (eg < 0) begin
            check_eq("grant_without_valid", 32'(req_ready), 32'd0);
          end else begin
            g = 2'(eg);
            check_eq("grant_onehot", 32'(req_ready), 32'd1 << eg);
            grant_log.push_back(eg);
            n_grant++;
            accept_cyc = cyc;
            job_addrs = 0;
            model_ptr = (eg + 1) % NR;
            inv = model_invalid(g);
            exp_cmp_id.push_back(g);
            exp_cmp_err.push_back(inv);
            exp_base = req_base[g];
            exp_len = req_length[g];
            if (!inv) begin
              for (int k = 0; k < int'(req_length[g]); k++) begin
                exp_addr.push_back(req_base[g] + 32'(k));
                exp_addr_id.push_back(g);
              end
            end
          end
        end
        if (agu_start) begin
          n_start++;
          check_eq("cfg_base", agu_base_addr, exp_base);
          check_eq("cfg_length", 32'(agu_length), 32'(exp_len));
        end
        if (agu_start && !prev_start) start_rise_cyc = cyc;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        if (agu_done && !prev_done) done_rise_cyc = cyc;
        prev_start = agu_start; prev_busy = busy; prev_done = agu_done;
        if (m_addr_valid && m_addr_ready) begin
          n_addr++;
          if (job_addrs == 0) first_addr_cyc = cyc;
          last_addr_cyc = cyc;
          job_addrs++;
          if (exp_addr.size() == 0) begin
            check_eq("unexpected_addr", m_addr, 32'hFFFF_FFFF);
          end else begin
            check_eq("m_addr", m_addr, exp_addr.pop_front());
            check_eq("m_addr_id", 32'(m_addr_id), 32'(exp_addr_id.pop_front()));
          end
        end
        if (cmp_valid) begin
          n_cmp++;
          last_cmp_cyc = cyc;
          if (exp_cmp_id.size() == 0) begin
            check_eq("unexpected_cmp", 32'(cmp_valid), 32'd0);
          end else begin
            inv = exp_cmp_err.pop_front();
            check_eq("cmp_id", 32'(cmp_id), 32'(exp_cmp_id.pop_front()));
            check_eq("cmp_err", 32'(cmp_err), 32'(inv));
            if (inv) check_eq("err_latency", 32'(cyc - accept_cyc), 32'd1);
            else     check_eq("cmp_latency", 32'(cyc - done_rise_cyc), 32'd3);
            comp_count[cmp_id]++;
          end
        end
      end
    end
  endtask

  task automatic set_desc(input logic [1:0] g, input access_pattern_e pat, input logic [31:0] base,
                          input logic [15:0] len, input logic [7:0] stride, input logic [7:0] width,
                          input logic [7:0] height, input logic [7:0] ksize);
    req_pattern[g] = pat; req_base[g] = base; req_length[g] = len;
    req_stride[g] = stride; req_width[g] = width; req_height[g] = height; req_ksize[g] = ksize;
  endtask

  task automatic wait_ready(input logic [1:0] g, input int budget);
    int n = 0;
    @(negedge clk);
    while (!req_ready[g] && n < budget) begin @(negedge clk); n++; end
    check_eq("ready_seen", 32'(req_ready[g]), 32'd1);
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
  endtask

  task automatic issue(input logic [1:0] g);
    @(posedge clk); #1;
    req_valid[g] = 1'b1;
    wait_ready(g, 60);
  endtask

  task automatic wait_cmp(input int target, input int budget);
    int n = 0;
    while (n_cmp < target && n < budget) begin @(posedge clk); n++; end
    check_eq("cmp_count", n_cmp, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, c0, g0, n;
    for (int i = 0; i < NR; i++) set_desc(2'(i), SEQUENTIAL, 32'd0, 16'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    fork monitor(); join_none

    // Reset values, during and right after reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(agu_start), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_start", 32'(agu_start), 32'd0);
    check_eq("idle_cmp_valid", 32'(cmp_valid), 32'd0);
    check_eq("idle_cmp_err", 32'(cmp_err), 32'd0);
    check_eq("idle_cmp_id", 32'(cmp_id), 32'd0);
    check_eq("idle_m_valid", 32'(m_addr_valid), 32'd0);
    check_eq("idle_agu_ready", 32'(agu_addr_ready), 32'd0);
    check_eq("idle_base", agu_base_addr, 32'd0);
    check_eq("idle_length", 32'(agu_length), 32'd0);

    // Round-robin with all three requesters held valid
    set_desc(2'd0, SEQUENTIAL, 32'h1000, 16'd2, 8'd1, 8'd1, 8'd1, 8'd1);
    set_desc(2'd1, SEQUENTIAL, 32'h2000, 16'd2, 8'd1, 8'd1, 8'd1, 8'd1);
    set_desc(2'd2, SEQUENTIAL, 32'h3000, 16'd2, 8'd1, 8'd1, 8'd1, 8'd1);
    c0 = n_cmp; g0 = n_grant; n = 0;
    @(posedge clk); #1 req_valid = 3'b111;
    while (n_grant < g0 + 6 && n < 600) begin @(posedge clk); n++; end
    #1 req_valid = 3'b000;
    wait_cmp(c0 + 6, 200);
    check_eq("rr_grants", grant_log.size(), g0 + 6);
    if (grant_log.size() >= g0 + 6)
      for (int i = 0; i < 6; i++) check_eq("rr_order", grant_log[g0 + i], i % NR);
    for (int i = 0; i < NR; i++) check_eq("rr_count", comp_count[i], 2);

    // Single sequential job timing
    set_desc(2'd0, SEQUENTIAL, 32'h100, 16'd4, 8'd1, 8'd1, 8'd1, 8'd1);
    c0 = n_cmp;
    issue(2'd0);
    wait_cmp(c0 + 1, 60);
    repeat (2) @(posedge clk);
    check_eq("start_at", 32'(start_rise_cyc - accept_cyc), 32'd1);
    check_eq("first_addr_at", 32'(first_addr_cyc - accept_cyc), 32'd2);
    check_eq("last_addr_at", 32'(last_addr_cyc - accept_cyc), 32'd5);
    check_eq("cmp_at", 32'(last_cmp_cyc - accept_cyc), 32'd10);
    check_eq("busy_fall_at", 32'(busy_fall_cyc - accept_cyc), 32'd11);

    // Rejected descriptors: zero length, then kernel wider than the window
    set_desc(2'd1, SEQUENTIAL, 32'h500, 16'd0, 8'd1, 8'd1, 8'd1, 8'd1);
    s0 = n_start; c0 = n_cmp;
    issue(2'd1);
    wait_cmp(c0 + 1, 20);
    repeat (2) @(posedge clk);
    check_eq("rej_len_no_start", n_start, s0);
    set_desc(2'd1, SLIDING_2D, 32'h600, 16'd4, 8'd1, 8'd4, 8'd8, 8'd5);
    s0 = n_start; c0 = n_cmp;
    issue(2'd1);
    wait_cmp(c0 + 1, 20);
    repeat (2) @(posedge clk);
    check_eq("rej_ksize_no_start", n_start, s0);

    // Back-pressure on the memory side
    set_desc(2'd0, SEQUENTIAL, 32'h700, 16'd3, 8'd1, 8'd1, 8'd1, 8'd1);
    a0 = n_addr; c0 = n_cmp; bp_mode = 1'b1;
    issue(2'd0);
    wait_cmp(c0 + 1, 80);
    repeat (2) @(posedge clk);
    bp_mode = 1'b0;
    check_eq("bp_addr_count", n_addr - a0, 3);
    check_eq("bp_leftover", exp_addr.size(), 0);

    // Abort mid-run
    set_desc(2'd0, SEQUENTIAL, 32'h800, 16'd8, 8'd1, 8'd1, 8'd1, 8'd1);
    a0 = n_addr; n = 0;
    issue(2'd0);
    while (n_addr < a0 + 2 && n < 50) begin @(posedge clk); n++; end
    check_eq("abort_progress", n_addr - a0, 2);
    #2 rst_n = 1'b0;
    exp_addr.delete(); exp_addr_id.delete(); exp_cmp_id.delete(); exp_cmp_err.delete();
    model_ptr = 0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_start", 32'(agu_start), 32'd0);
    check_eq("abort_m_valid", 32'(m_addr_valid), 32'd0);
    check_eq("abort_agu_ready", 32'(agu_addr_ready), 32'd0);
    check_eq("abort_cmp_valid", 32'(cmp_valid), 32'd0);
    check_eq("abort_base", agu_base_addr, 32'd0);
    c0 = n_cmp;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check_eq("abort_no_cmp", n_cmp, c0);
    set_desc(2'd0, SEQUENTIAL, 32'h900, 16'd2, 8'd1, 8'd1, 8'd1, 8'd1);
    set_desc(2'd2, SEQUENTIAL, 32'hA00, 16'd2, 8'd1, 8'd1, 8'd1, 8'd1);
    #1 req_valid = 3'b101;
    n = 0;
    @(negedge clk);
    while (req_ready == 3'b000 && n < 20) begin @(negedge clk); n++; end
    check_eq("abort_next_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_ready(2'd2, 60);
    wait_cmp(c0 + 2, 100);

    // Hold gating: requester 2 arrives while a job runs
    set_desc(2'd0, SEQUENTIAL, 32'hB00, 16'd4, 8'd1, 8'd1, 8'd1, 8'd1);
    set_desc(2'd2, SEQUENTIAL, 32'hC00, 16'd2, 8'd1, 8'd1, 8'd1, 8'd1);
    c0 = n_cmp;
    issue(2'd0);
    repeat (2) @(posedge clk);
    #1 req_valid[2] = 1'b1;
    @(negedge clk);
    check_eq("hold_ready_run", 32'(req_ready[2]), 32'd0);
    wait_ready(2'd2, 60);
    check_eq("hold_grant_after_resp", 32'(accept_cyc - last_cmp_cyc), 32'd1);
    wait_cmp(c0 + 2, 60);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/agu_scheduler.md
# agu_scheduler

Shares one `addr_gen_unit` between NUM_REQ fetch clients (e.g. weight, activation, writeback) with round-robin arbitration. It latches a descriptor, validates it, and drives the AGU start/hold/release handshake. It forwards the AGU address stream tagged with the owner id and returns a one-cycle completion per job. It sits between the layer controllers and the AGU inside each accelerator core.

## Interface
- `NUM_REQ`, default 3: number of requesters (2..8). `ID_W = $clog2(NUM_REQ)`. `ADDR_WIDTH` and `access_pattern_e` come from `accel_pkg`.
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NUM_REQ: descriptor valid, one bit per requester. Must hold stable until its `req_ready` bit is 1.
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `req_pattern` in NUM_REQ × access_pattern_e: access pattern.
- `req_base` in NUM_REQ × ADDR_WIDTH: base address.
- `req_length` in NUM_REQ × 16: transfer length.
- `req_stride`, `req_width`, `req_height`, `req_ksize` in NUM_REQ × 8 each: 2D configuration.
- `agu_start` out 1, `agu_pattern` out, `agu_base_addr` out ADDR_WIDTH, `agu_length` out 16, `agu_stride`/`agu_width`/`agu_height`/`agu_kernel_size` out 8 each: AGU control. Config outputs are driven from the latched descriptor.
- `agu_done` in 1: AGU done level.
- `agu_addr` in ADDR_WIDTH, `agu_addr_valid` in 1, `agu_addr_ready` out 1: AGU address stream.
- `m_addr` out ADDR_WIDTH, `m_addr_valid` out 1, `m_addr_ready` in 1, `m_addr_id` out ID_W: tagged address stream to the memory side.
- `cmp_valid` out 1: one-cycle completion pulse.
- `cmp_id` out ID_W: id of the completed job.
- `cmp_err` out 1: descriptor was rejected.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states are IDLE, RUN, RELEASE and RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is set, grant the first set bit scanning from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - `req_ready[g]` is 1 combinationally in that cycle. Latch the descriptor and `cur_id = g`. Set `rr_ptr <= (g+1) mod NUM_REQ`.
  - Go to RESP with err=1 if the descriptor is invalid. Otherwise go to RUN.
- **Invalid descriptor** is any of:
  - `length == 0`.
  - Pattern SLIDING_2D with `stride == 0`, `ksize == 0`, `ksize > width`, or `ksize > height`.
- **RUN**
  - `agu_start = 1`.
  - `m_addr = agu_addr`, `m_addr_valid = agu_addr_valid`, `agu_addr_ready = m_addr_ready`, `m_addr_id = cur_id`.
  - On `agu_done == 1`, go to RELEASE.
- **RELEASE**
  - `agu_start = 0`.
  - When `agu_done == 0`, go to RESP with err=0.
- **RESP**
  - Registered outputs `cmp_valid = 1`, `cmp_id = cur_id`, `cmp_err` as latched. Go to IDLE.
- Outside RUN: `m_addr_valid = 0` and `agu_addr_ready = 0`. `req_ready` is all-zero outside IDLE.
- The `cmp_*` outputs have no back-pressure. Consumers must sample them on the pulse.

## Timing
- **Reset values:** state IDLE; `rr_ptr = 0`; `agu_start`, `cmp_valid`, `cmp_err`, `busy`, `req_ready`, `m_addr_valid` and `agu_addr_ready` all 0; latched config, `cur_id` and `cmp_id` all 0.
- **Reset mid-job:** the job is dropped and no completion is issued. The AGU shares `rst_n`.
- **Accept:** at cycle T, `agu_start` is 1 from T+1.
- **Completion:** `cmp_valid` is 1 exactly three cycles after `agu_done` first reads 1: RELEASE +1, done-low seen +1, RESP +1. This assumes the AGU drops done one cycle after start falls.
- **Next grant:** the next grant is possible in the cycle after RESP.
- **Invalid descriptor:** accepted at T, `cmp_valid` and `cmp_err` at T+1, and `agu_start` never rises.
- **Simultaneous requests:** exactly one grant per IDLE cycle. A requester that is not granted keeps `req_valid` asserted.
- **Control outputs:** `agu_start` is a pure state decode, free of glitches relative to `clk`. Config outputs are stable for the entire job.

## Test plan
- **Single sequential job.** Req0 sequential, base 0x100, length 4, `m_addr_ready = 1`, real AGU, accept at cycle 0. Expect:
  - `m_addr` 0x100..0x103 with id 0 in cycles 2-5;
  - `agu_done` at 7;
  - `cmp_valid` at 10 with id 0 and err 0;
  - `busy` falls at 11.
- **Round-robin.** All three requesters valid continuously. Expect grants in the order 0, 1, 2, 0, and every requester's completion count equal after 6 jobs.
- **Rejected descriptors.** Req1 with `length = 0`: `req_ready[1]` at T, `cmp_err = 1` with id 1 at T+1, `agu_start` never 1. Repeat with SLIDING_2D `ksize = 5`, `width = 4`: same response.
- **Back-pressure.** Sequential length 3 with `m_addr_ready` toggling 1,0,1,0. Expect exactly 3 addresses, none duplicated or lost, and `cmp_valid` three cycles after `agu_done` rises.
- **Abort.** Assert `rst_n` low mid-RUN at address 2 of 8. Expect all outputs at reset values asynchronously, no `cmp_valid`, and the next request granted to requester 0.
- **Hold gating.** Requester 2 valid in RUN state. Expect `req_ready[2] = 0` until IDLE, descriptor values unchanged, and the grant in the cycle after RESP.
